// File: rtl/tile_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tile_sprite_compositor
// Purpose  : Tile/sprite compositor for a VGA pixel pipeline. Derives tile
//            and pixel-in-tile coordinates from the sync counters, scans the
//            entity list one entry per clock for the next tile's winner,
//            addresses an external 1-cycle sprite ROM and emits a 1-bit
//            colour per pixel with optional H/V flip.
// Options  : TSC_COLLISION_EN - adds the 'collision' output, high for a whole
//            tile when two or more enabled entities target it.
// Revision : 1.0 - initial release
// ============================================================================
module tile_sprite_compositor #(
  parameter int   NUM_ENTITIES = 9,
  parameter int   UPSCALE      = 5,
  parameter int   TILE_PX      = 8,
  parameter int   TILES_H      = 16,
  parameter int   TILES_V      = 12,
  parameter logic BG_COLOUR    = 1'b0
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [14*NUM_ENTITIES-1:0] entities,
  input  logic [2*NUM_ENTITIES-1:0]  entity_mode,
  input  logic [9:0]                counter_H,
  input  logic [9:0]                counter_V,
  output logic [3:0]                rom_sprite_id,
  output logic [1:0]                rom_orient,
  output logic [2:0]                rom_line,
  input  logic [7:0]                rom_data,
  output logic                      tile_hit,
`ifdef TSC_COLLISION_EN
  output logic                      collision,
`endif
  output logic                      colour
);

  localparam int            TILE_W   = TILE_PX * UPSCALE;
  localparam logic [9:0]    TILE_W10 = 10'(TILE_W);
  localparam logic [9:0]    UP10     = 10'(UPSCALE);
  localparam logic [9:0]    ACT_W10  = 10'(TILES_H * TILE_W);
  localparam logic [9:0]    ACT_H10  = 10'(TILES_V * TILE_W);
  localparam logic [3:0]    LAST_TX  = 4'(TILES_H - 1);
  localparam logic [3:0]    LAST_TY  = 4'(TILES_V - 1);
  localparam int            IW       = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTITIES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Coordinates, derived purely from the sync counters
  // --------------------------------------------------------------------------
  logic [9:0] off_h_w, off_v_w;
  logic [3:0] tile_x_w, tile_y_w;
  logic [2:0] col_w, row_w;
  logic       active_w, tile_start_w, latch_pt_w, tile_end_w;
  logic [3:0] tgt_x_w, tgt_y_w;

  assign off_h_w      = counter_H % TILE_W10;
  assign off_v_w      = counter_V % TILE_W10;
  assign tile_x_w     = 4'(counter_H / TILE_W10);
  assign tile_y_w     = 4'(counter_V / TILE_W10);
  assign col_w        = 3'(off_h_w / UP10);
  assign row_w        = 3'(off_v_w / UP10);
  assign active_w     = (counter_H < ACT_W10) && (counter_V < ACT_H10);
  assign tile_start_w = (off_h_w == 10'd0);
  assign latch_pt_w   = (off_h_w == TILE_W10 - 10'd2);
  assign tile_end_w   = (off_h_w == TILE_W10 - 10'd1);

  // Next tile to the right; the last column wraps to the start of the next row, the last row to the top
  always_comb begin
    tgt_x_w = tile_x_w + 4'd1;
    tgt_y_w = tile_y_w;
    if (tile_x_w == LAST_TX) begin
      tgt_x_w = 4'd0;
      tgt_y_w = (tile_y_w == LAST_TY) ? 4'd0 : tile_y_w + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Entity list unpacking and per-entry match
  // --------------------------------------------------------------------------
  logic [13:0] ent_arr  [NUM_ENTITIES];
  logic [1:0]  mode_arr [NUM_ENTITIES];

  generate
    for (genvar g = 0; g < NUM_ENTITIES; g++) begin : g_unpack
      assign ent_arr[g]  = entities[14*g +: 14];
      assign mode_arr[g] = entity_mode[2*g +: 2];
    end
  endgenerate

  state_t      state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic        acc_hit_q, acc_hit_d;
  logic [3:0]  acc_id_q, acc_id_d;
  logic [1:0]  acc_orient_q, acc_orient_d;
  logic        acc_vflip_q, acc_vflip_d;
  logic        acc_hflip_q, acc_hflip_d;
`ifdef TSC_COLLISION_EN
  logic        acc_multi_q, acc_multi_d;
`endif

  logic [13:0] cur_ent_w;
  logic [1:0]  cur_mode_w;
  logic        match_w;

  assign cur_ent_w  = ent_arr[idx_q];
  assign cur_mode_w = mode_arr[idx_q];
  assign match_w    = (cur_ent_w[13:10] != 4'hF) && (cur_mode_w != 2'b11) &&
                      (cur_ent_w[7:4] == tgt_x_q) && (cur_ent_w[3:0] == tgt_y_q);

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  // State register for the scan and its winner accumulator; reset aborts any scan in flight
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tgt_x_q      <= '0;
      tgt_y_q      <= '0;
      acc_hit_q    <= 1'b0;
      acc_id_q     <= '0;
      acc_orient_q <= '0;
      acc_vflip_q  <= 1'b0;
      acc_hflip_q  <= 1'b0;
`ifdef TSC_COLLISION_EN
      acc_multi_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tgt_x_q      <= tgt_x_d;
      tgt_y_q      <= tgt_y_d;
      acc_hit_q    <= acc_hit_d;
      acc_id_q     <= acc_id_d;
      acc_orient_q <= acc_orient_d;
      acc_vflip_q  <= acc_vflip_d;
      acc_hflip_q  <= acc_hflip_d;
`ifdef TSC_COLLISION_EN
      acc_multi_q  <= acc_multi_d;
`endif
    end
  end

  // Next-state logic: start at each tile's first pixel, one entity per clock, first match wins
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tgt_x_d      = tgt_x_q;
    tgt_y_d      = tgt_y_q;
    acc_hit_d    = acc_hit_q;
    acc_id_d     = acc_id_q;
    acc_orient_d = acc_orient_q;
    acc_vflip_d  = acc_vflip_q;
    acc_hflip_d  = acc_hflip_q;
`ifdef TSC_COLLISION_EN
    acc_multi_d  = acc_multi_q;
`endif
    if (!active_w) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tile_start_w) begin
            // Target is frozen here so a mid-tile row step cannot disturb this scan
            state_d   = S_SCAN;
            idx_d     = '0;
            tgt_x_d   = tgt_x_w;
            tgt_y_d   = tgt_y_w;
            acc_hit_d = 1'b0;
`ifdef TSC_COLLISION_EN
            acc_multi_d = 1'b0;
`endif
          end
        end
        S_SCAN: begin
          if (match_w) begin
            if (!acc_hit_q) begin
              acc_hit_d    = 1'b1;
              acc_id_d     = cur_ent_w[13:10];
              acc_orient_d = cur_ent_w[9:8];
              acc_vflip_d  = (cur_mode_w == 2'b01);
              acc_hflip_d  = (cur_mode_w == 2'b10);
            end
`ifdef TSC_COLLISION_EN
            else begin
              acc_multi_d = 1'b1;
            end
`endif
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_HOLD: begin
          if (tile_end_w) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Winner latch and ROM addressing (two pixels before the tile boundary)
  // --------------------------------------------------------------------------
  logic       win_hit_q, win_hflip_q;
  logic [3:0] rom_id_q;
  logic [1:0] rom_orient_q;
  logic [2:0] rom_line_q;
`ifdef TSC_COLLISION_EN
  logic       win_coll_q;
`endif

  // Latch the scan result and address the ROM; the address is left untouched when nothing won
  always_ff @(posedge clk_in) begin
    if (reset) begin
      win_hit_q    <= 1'b0;
      win_hflip_q  <= 1'b0;
      rom_id_q     <= 4'hF;
      rom_orient_q <= 2'b11;
      rom_line_q   <= 3'b111;
`ifdef TSC_COLLISION_EN
      win_coll_q   <= 1'b0;
`endif
    end else if (active_w && latch_pt_w) begin
      win_hit_q   <= acc_hit_q;
      win_hflip_q <= acc_hflip_q;
`ifdef TSC_COLLISION_EN
      win_coll_q  <= acc_multi_q;
`endif
      if (acc_hit_q) begin
        rom_id_q     <= acc_id_q;
        rom_orient_q <= acc_orient_q;
        rom_line_q   <= acc_vflip_q ? ~row_w : row_w;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display stage: per-tile state swapped in at the boundary, per-pixel pipe
  // --------------------------------------------------------------------------
  logic       disp_hit_q, disp_hflip_q;
  logic [7:0] disp_line_q;
`ifdef TSC_COLLISION_EN
  logic       disp_coll_q;
`endif

  // Capture the ROM line and winner attributes for the tile that starts now
  always_ff @(posedge clk_in) begin
    if (reset) begin
      disp_hit_q   <= 1'b0;
      disp_hflip_q <= 1'b0;
      disp_line_q  <= '0;
`ifdef TSC_COLLISION_EN
      disp_coll_q  <= 1'b0;
`endif
    end else if (tile_start_w) begin
      disp_hit_q   <= win_hit_q;
      disp_hflip_q <= win_hflip_q;
      disp_line_q  <= rom_data;
`ifdef TSC_COLLISION_EN
      disp_coll_q  <= win_coll_q;
`endif
    end
  end

  logic       p1_active_q;
  logic [2:0] p1_col_q;
  logic [2:0] col_sel_w;
  logic       colour_q, tile_hit_q;
`ifdef TSC_COLLISION_EN
  logic       coll_q;
`endif

  // First pixel stage: hold this pixel's column so the display state for its tile is in place
  always_ff @(posedge clk_in) begin
    if (reset) begin
      p1_active_q <= 1'b0;
      p1_col_q    <= '0;
    end else begin
      p1_active_q <= active_w;
      p1_col_q    <= col_w;
    end
  end

  assign col_sel_w = disp_hflip_q ? ~p1_col_q : p1_col_q;

  // Output stage: pick the sprite bit, background where uncovered or blanked
  always_ff @(posedge clk_in) begin
    if (reset) begin
      colour_q   <= 1'b1;
      tile_hit_q <= 1'b0;
`ifdef TSC_COLLISION_EN
      coll_q     <= 1'b0;
`endif
    end else begin
      colour_q   <= (p1_active_q && disp_hit_q) ? disp_line_q[col_sel_w] : BG_COLOUR;
      tile_hit_q <= p1_active_q && disp_hit_q;
`ifdef TSC_COLLISION_EN
      coll_q     <= p1_active_q && disp_coll_q;
`endif
    end
  end

  assign rom_sprite_id = rom_id_q;
  assign rom_orient    = rom_orient_q;
  assign rom_line      = rom_line_q;
  assign tile_hit      = tile_hit_q;
  assign colour        = colour_q;
`ifdef TSC_COLLISION_EN
  assign collision     = coll_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_sprite_compositor
// Purpose  : Directed, table-driven bench for tile_sprite_compositor with a
//            1-cycle sprite ROM model keyed on sprite ID.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_sprite_compositor;

  localparam int N = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic [14*N-1:0]  entities;
  logic [2*N-1:0]   entity_mode;
  logic [9:0]       counter_H;
  logic [9:0]       counter_V;
  logic [3:0]       rom_sprite_id;
  logic [1:0]       rom_orient;
  logic [2:0]       rom_line;
  logic [7:0]       rom_data;
  logic             tile_hit;
  logic             colour;
`ifdef TSC_COLLISION_EN
  logic             collision;
`endif

  tile_sprite_compositor dut (
    .clk_in        (clk),
    .reset         (reset),
    .entities      (entities),
    .entity_mode   (entity_mode),
    .counter_H     (counter_H),
    .counter_V     (counter_V),
    .rom_sprite_id (rom_sprite_id),
    .rom_orient    (rom_orient),
    .rom_line      (rom_line),
    .rom_data      (rom_data),
    .tile_hit      (tile_hit),
`ifdef TSC_COLLISION_EN
    .collision     (collision),
`endif
    .colour        (colour)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [3:0] id);
    case (id)
      4'd3:    rom_fn = 8'h0F;
      4'd7:    rom_fn = 8'hF0;
      default: rom_fn = 8'h81;
    endcase
  endfunction

  // Sprite ROM: line available one clock after the address
  always @(posedge clk) rom_data <= rom_fn(rom_sprite_id);

  int   n_checks = 0;
  int   n_fail   = 0;
  logic cap_colour [800];
  logic cap_hit    [800];
  logic cap_coll   [800];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One pixel clock at (h, v); afterwards colour reflects pixel h-1
  task automatic step(input int h, input int v);
    int p;
    counter_H = 10'(h);
    counter_V = 10'(v);
    @(posedge clk);
    #1;
    p = (h == 0) ? 799 : h - 1;
    cap_colour[p] = colour;
    cap_hit[p]    = tile_hit;
`ifdef TSC_COLLISION_EN
    cap_coll[p]   = collision;
`else
    cap_coll[p]   = 1'b0;
`endif
  endtask

  task automatic sweep(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(h, v);
  endtask

  task automatic clear_ents();
    entities    = '1;
    entity_mode = '0;
  endtask

  task automatic set_ent(input int k, input logic [3:0] id, input logic [1:0] orient,
                         input logic [3:0] x, input logic [3:0] y, input logic [1:0] mode);
    entities[14*k +: 14]  = {id, orient, x, y};
    entity_mode[2*k +: 2] = mode;
  endtask

  typedef struct {
    logic [3:0] id;
    logic [1:0] orient;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] mode;
    int         v;
    int         h;
    logic       exp_c;
    logic       exp_h;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int vprev;
    vecs[0]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b00, 40,  80, 1'b1, 1'b1};
    vecs[1]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b00, 40,  99, 1'b1, 1'b1};
    vecs[2]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b00, 40, 100, 1'b0, 1'b1};
    vecs[3]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b00, 40, 119, 1'b0, 1'b1};
    vecs[4]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b00, 40,  79, 1'b0, 1'b0};
    vecs[5]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b00, 40, 120, 1'b0, 1'b0};
    vecs[6]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b10, 40,  80, 1'b0, 1'b1};
    vecs[7]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b10, 40, 119, 1'b1, 1'b1};
    vecs[8]  = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b01, 40,  80, 1'b1, 1'b1};
    vecs[9]  = '{4'd3, 2'd0, 4'd0,  4'd0, 2'b11,  0,   0, 1'b0, 1'b0};
    vecs[10] = '{4'd3, 2'd0, 4'd0,  4'd0, 2'b00,  0,   0, 1'b1, 1'b1};
    vecs[11] = '{4'd3, 2'd0, 4'd0,  4'd1, 2'b00, 40,   0, 1'b1, 1'b1};
    vecs[12] = '{4'd3, 2'd0, 4'd0,  4'd1, 2'b00, 40,  39, 1'b0, 1'b1};
    vecs[13] = '{4'hF, 2'd0, 4'd2,  4'd1, 2'b00, 40,  80, 1'b0, 1'b0};
    vecs[14] = '{4'd3, 2'd0, 4'd2,  4'd1, 2'b00, 79, 101, 1'b0, 1'b1};
    vecs[15] = '{4'd3, 2'd0, 4'd2,  4'd2, 2'b00, 40,  80, 1'b0, 1'b0};
    vecs[16] = '{4'd7, 2'd0, 4'd15, 4'd1, 2'b00, 40, 600, 1'b0, 1'b1};
    vecs[17] = '{4'd7, 2'd0, 4'd15, 4'd1, 2'b00, 40, 639, 1'b1, 1'b1};
    vecs[18] = '{4'd3, 2'd0, 4'd0,  4'd0, 2'b00,  0, 700, 1'b0, 1'b0};

    // Reset held for three clocks
    reset = 1'b1;
    clear_ents();
    repeat (3) step(0, 0);
    chk("reset colour", 8'(colour), 8'd1);
    chk("reset tile_hit", 8'(tile_hit), 8'd0);
    chk("reset rom_sprite_id", 8'(rom_sprite_id), 8'hF);
    chk("reset rom_orient", 8'(rom_orient), 8'd3);
    chk("reset rom_line", 8'(rom_line), 8'd7);
    reset = 1'b0;
    sweep(0, 0, 50);
    chk("idle colour px10", 8'(cap_colour[10]), 8'd0);
    chk("idle colour px45", 8'(cap_colour[45]), 8'd0);
    chk("idle hit px45", 8'(cap_hit[45]), 8'd0);

    // Single-entity vector table
    for (int i = 0; i < 19; i++) begin
      clear_ents();
      set_ent(0, vecs[i].id, vecs[i].orient, vecs[i].x, vecs[i].y, vecs[i].mode);
      vprev = (vecs[i].v == 0) ? 479 : vecs[i].v - 1;
      sweep(vprev, 560, 799);
      sweep(vecs[i].v, 0, vecs[i].h + 1);
      chk($sformatf("vec%0d colour", i), 8'(cap_colour[vecs[i].h]), 8'(vecs[i].exp_c));
      chk($sformatf("vec%0d tile_hit", i), 8'(cap_hit[vecs[i].h]), 8'(vecs[i].exp_h));
    end

    // Priority: entity 0 beats entity 5 on the same tile
    clear_ents();
    set_ent(0, 4'd3, 2'd0, 4'd4, 4'd0, 2'b00);
    set_ent(5, 4'd7, 2'd0, 4'd4, 4'd0, 2'b00);
    sweep(479, 560, 799);
    sweep(0, 0, 201);
    chk("prio rom_sprite_id", 8'(rom_sprite_id), 8'd3);
    chk("prio colour px160", 8'(cap_colour[160]), 8'd1);
    chk("prio colour px195", 8'(cap_colour[195]), 8'd0);
`ifdef TSC_COLLISION_EN
    chk("coll px159", 8'(cap_coll[159]), 8'd0);
    chk("coll px160", 8'(cap_coll[160]), 8'd1);
    chk("coll px199", 8'(cap_coll[199]), 8'd1);
    chk("coll px200", 8'(cap_coll[200]), 8'd0);
`endif

    // Disabled entity 0 lets entity 5 through
    set_ent(0, 4'd3, 2'd0, 4'd4, 4'd0, 2'b11);
    sweep(479, 560, 799);
    sweep(0, 0, 201);
    chk("prio2 rom_sprite_id", 8'(rom_sprite_id), 8'd7);
    chk("prio2 colour px195", 8'(cap_colour[195]), 8'd1);

    // ROM addressing: V-flip line and orientation pass-through (V=45 -> row 1)
    clear_ents();
    set_ent(0, 4'd3, 2'd2, 4'd2, 4'd1, 2'b01);
    sweep(44, 560, 799);
    sweep(45, 0, 81);
    chk("vflip rom_line", 8'(rom_line), 8'd6);
    chk("vflip rom_orient", 8'(rom_orient), 8'd2);
    set_ent(0, 4'd3, 2'd2, 4'd2, 4'd1, 2'b00);
    sweep(44, 560, 799);
    sweep(45, 0, 81);
    chk("normal rom_line", 8'(rom_line), 8'd1);

    // Reset pulse mid-scan at H=85: tile 3 lost, tile 4 valid
    clear_ents();
    set_ent(0, 4'd3, 2'd0, 4'd3, 4'd1, 2'b00);
    set_ent(1, 4'd3, 2'd0, 4'd4, 4'd1, 2'b00);
    sweep(39, 560, 799);
    sweep(40, 0, 84);
    reset = 1'b1;
    for (int h = 85; h <= 87; h++) begin
      step(h, 40);
      chk($sformatf("rstpulse colour H%0d", h), 8'(colour), 8'd1);
    end
    reset = 1'b0;
    sweep(40, 88, 201);
    chk("rstpulse colour px100", 8'(cap_colour[100]), 8'd0);
    chk("rstpulse hit px120", 8'(cap_hit[120]), 8'd0);
    chk("rstpulse colour px120", 8'(cap_colour[120]), 8'd0);
    chk("rstpulse hit px160", 8'(cap_hit[160]), 8'd1);
    chk("rstpulse colour px160", 8'(cap_colour[160]), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
